// File: rtl/asg_dac_pkg.sv
// Shared types and constants for the ASG DAC output conditioning path.
package asg_dac_pkg;

  localparam int          DW_DEF     = 14;
  localparam int          GAIN_FRAC  = 14;
  localparam logic [15:0] GAIN_UNITY = 16'h4000;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } dac_state_e;

endpackage

// File: rtl/asg_dac_slew_if.sv
// Sample, configuration and status bundle between the ASG channel and the DAC slew block.
interface asg_dac_slew_if
  import asg_dac_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic signed [DW-1:0] dat_i;
  logic                 set_en_i;
  logic                 set_kill_i;
  logic [15:0]          set_gain_i;
  logic signed [DW-1:0] set_ofs_i;
  logic [DW-1:0]        set_slew_i;
  logic signed [DW-1:0] dac_o;
  logic [DW-1:0]        dac_dat_o;
  logic [1:0]           state_o;
  logic                 busy_o;
  logic                 limit_o;

  modport master (
    output dat_i, set_en_i, set_kill_i, set_gain_i, set_ofs_i, set_slew_i,
    input  dac_o, dac_dat_o, state_o, busy_o, limit_o
  );

  modport slave (
    input  dat_i, set_en_i, set_kill_i, set_gain_i, set_ofs_i, set_slew_i,
    output dac_o, dac_dat_o, state_o, busy_o, limit_o
  );

endinterface

// File: rtl/asg_dac_cal.sv
// Two-stage calibration: Q2.14 gain multiply, then offset add with saturation to DW bits.
module asg_dac_cal
  import asg_dac_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic [15:0]          gain_i,
  input  logic signed [DW-1:0] ofs_i,
  output logic signed [DW-1:0] cal_o
);

  localparam int PW = DW + 17;
  localparam int SW = DW + 3;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [PW-1:0] prod_q, prod_d, prod_sh;
  logic signed [SW-1:0] sum;
  logic signed [DW-1:0] cal_q, cal_d;

  always_comb begin
    // gain is unsigned; a zero MSB keeps it positive in the signed multiply
    prod_d  = PW'(dat_i) * PW'($signed({1'b0, gain_i}));
    prod_sh = prod_q >>> GAIN_FRAC;
    sum     = SW'(prod_sh) + SW'(ofs_i);
    if (sum > MAX_V) begin
      cal_d = MAX_V[DW-1:0];
    end else if (sum < MIN_V) begin
      cal_d = MIN_V[DW-1:0];
    end else begin
      cal_d = sum[DW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prod_q <= '0;
      cal_q  <= '0;
    end else begin
      prod_q <= prod_d;
      cal_q  <= cal_d;
    end
  end

  assign cal_o = cal_q;

endmodule

// File: rtl/asg_dac_slew.sv
// DAC output conditioning: calibrated sample, enable/kill sequencing and per-cycle slew limiter.
//   state        | meaning
//   ST_OFF       | output held at zero, waiting for enable
//   ST_RAMP_UP   | slewing from current output toward calibrated sample
//   ST_RUN       | tracking calibrated sample, slew limit still applied
//   ST_RAMP_DOWN | slewing from current output toward zero
module asg_dac_slew
  import asg_dac_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic           dac_clk_i,
  input  logic           dac_rstn_i,
  asg_dac_slew_if.slave  bus
);

  logic signed [DW-1:0] cal;
  logic signed [DW-1:0] target;
  logic signed [DW:0]   diff, dac_x, slew_x, stepped;
  logic [DW:0]          mag;
  logic                 clamp;
  logic signed [DW-1:0] dac_step;

  dac_state_e           state_q, state_d;
  logic signed [DW-1:0] dac_q, dac_d;
  logic [DW-1:0]        dac_dat_q;
  logic                 busy_q, limit_q, limit_d;

  asg_dac_cal #(.DW(DW)) u_cal (
    .clk_i  (dac_clk_i),
    .rstn_i (dac_rstn_i),
    .dat_i  (bus.dat_i),
    .gain_i (bus.set_gain_i),
    .ofs_i  (bus.set_ofs_i),
    .cal_o  (cal)
  );

  always_comb begin
    target   = (state_q == ST_RAMP_UP || state_q == ST_RUN) ? cal : '0;
    dac_x    = (DW+1)'(dac_q);
    slew_x   = $signed({1'b0, bus.set_slew_i});
    diff     = (DW+1)'(target) - dac_x;
    mag      = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    clamp    = (bus.set_slew_i != '0) && (mag > {1'b0, bus.set_slew_i});
    // a clamped step lies strictly between dac_q and target, so it always fits DW bits
    stepped  = diff[DW] ? (dac_x - slew_x) : (dac_x + slew_x);
    dac_step = clamp ? stepped[DW-1:0] : target;
  end

  always_comb begin
    state_d = state_q;
    dac_d   = dac_step;
    limit_d = clamp;
    if (bus.set_kill_i) begin
      state_d = ST_OFF;
      dac_d   = '0;
      limit_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          dac_d   = '0;
          limit_d = 1'b0;
          if (bus.set_en_i) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!bus.set_en_i)  state_d = ST_RAMP_DOWN;
          else if (!clamp)    state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.set_en_i)  state_d = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (bus.set_en_i)   state_d = ST_RAMP_UP;
          else if (!clamp)    state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q   <= ST_OFF;
      dac_q     <= '0;
      dac_dat_q <= {1'b0, {(DW-1){1'b1}}};
      busy_q    <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      dac_dat_q <= {dac_d[DW-1], ~dac_d[DW-2:0]};
      busy_q    <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
      limit_q   <= limit_d;
    end
  end

  assign bus.dac_o     = dac_q;
  assign bus.dac_dat_o = dac_dat_q;
  assign bus.state_o   = state_q;
  assign bus.busy_o    = busy_q;
  assign bus.limit_o   = limit_q;

endmodule
